// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write arbiter: byte width, default parameters, FSM encoding.
// Latency: none (definitions only).
// Backpressure: not applicable.
package i2c_pkg;

    localparam int I2C_BYTE_W    = 8;
    localparam int DEF_NREQ      = 4;
    localparam int DEF_MAX_RETRY = 2;
    localparam int DEF_GAP       = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/i2c_write_arbiter_rr_select.sv
// Round-robin picker: one-hot winner among req_i, priority starting at index ptr_i.
// Latency: combinational.
// Backpressure: none; the caller decides when to sample gnt_o.
module rr_select #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    logic found;

    // Two passes: first indices at/after the pointer, then the wrapped-around ones.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (PW'(i) >= ptr_i)) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (PW'(i) < ptr_i)) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_write_arbiter.sv
// Shares one I2C byte-write master among NREQ requesters with round-robin grant and NACK retry.
// Latency: req in IDLE at cycle n -> grant at n+2, m_start at n+3 when the master is idle.
// Backpressure: holds in ISSUE while m_busy is high; requesters hold req until done/err.
module i2c_write_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int MAX_RETRY = DEF_MAX_RETRY,
    parameter int GAP       = DEF_GAP
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NREQ-1:0]              req,
    input  logic [I2C_BYTE_W*NREQ-1:0]   req_addr,
    input  logic [I2C_BYTE_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]              grant,
    output logic [NREQ-1:0]              done,
    output logic [NREQ-1:0]              err,
    output logic                         m_start,
    output logic [I2C_BYTE_W-1:0]        m_addr,
    output logic [I2C_BYTE_W-1:0]        m_data,
    input  logic                         m_busy,
    input  logic                         m_done,
    input  logic                         m_nack
);

    localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);
    localparam logic [3:0]  GAP_LOAD  = 4'(GAP - 1);

    state_t                 state_q;
    logic [NREQ-1:0]        grant_q;
    logic [NREQ-1:0]        done_q;
    logic [NREQ-1:0]        err_q;
    logic                   m_start_q;
    logic [I2C_BYTE_W-1:0]  m_addr_q;
    logic [I2C_BYTE_W-1:0]  m_data_q;
    logic [2:0]             retry_q;
    logic [3:0]             gap_q;
    logic [PW-1:0]          ptr_q;

    logic [NREQ-1:0]        sel_gnt;
    logic [I2C_BYTE_W-1:0]  sel_addr;
    logic [I2C_BYTE_W-1:0]  sel_data;
    logic [PW-1:0]          win_idx;
    logic [PW-1:0]          ptr_d;

    rr_select #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_select (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (sel_gnt)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_gnt[i]) begin
                sel_addr = req_addr[I2C_BYTE_W*i +: I2C_BYTE_W];
                sel_data = req_data[I2C_BYTE_W*i +: I2C_BYTE_W];
            end
        end
    end

    // Next arbitration starts just after the requester that was served.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                win_idx = PW'(i);
            end
        end
        ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            m_start_q <= 1'b0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
            retry_q   <= '0;
            gap_q     <= '0;
            ptr_q     <= '0;
        end else begin
            done_q    <= '0;
            err_q     <= '0;
            m_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (|sel_gnt) begin
                        grant_q  <= sel_gnt;
                        m_addr_q <= sel_addr;
                        m_data_q <= sel_data;
                        state_q  <= ST_ISSUE;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!m_busy) begin
                        m_start_q <= 1'b1;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_done) begin
                        gap_q   <= GAP_LOAD;
                        state_q <= ST_GAP;
                        if (!m_nack) begin
                            done_q  <= grant_q;
                            retry_q <= '0;
                        end else if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 1'b1;
                        end else begin
                            err_q   <= grant_q;
                            retry_q <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    // A nonzero retry count is exactly the "re-issue pending" condition.
                    if (gap_q == '0) begin
                        if (retry_q != '0) begin
                            state_q <= ST_ISSUE;
                        end else begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                            ptr_q   <= ptr_d;
                        end
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign m_start = m_start_q;
    assign m_addr  = m_addr_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Directed bench for i2c_write_arbiter: latency, round-robin order, retry, exhaustion, reset, busy master.
// The bench plays the master itself, answering each m_start with an m_done pulse.
module tb_i2c_write_arbiter;

    localparam int NREQ = 4;
    localparam int GAPC = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        m_start;
    logic [7:0]  m_addr;
    logic [7:0]  m_data;
    logic        m_busy;
    logic        m_done;
    logic        m_nack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    i2c_write_arbiter #(
        .NREQ      (NREQ),
        .MAX_RETRY (2),
        .GAP       (GAPC)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .m_start  (m_start),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_busy   (m_busy),
        .m_done   (m_done),
        .m_nack   (m_nack)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag, input int budget);
        for (int i = 0; i < budget && !m_start; i++) tick();
        chk(tag, m_start, 1);
    endtask

    // Called in the m_start cycle; returns in the cycle where done/err is visible.
    task automatic master_resp(input logic nack);
        tick();
        chk("start_one_cycle", m_start, 0);
        m_done = 1'b1;
        m_nack = nack;
        tick();
        m_done = 1'b0;
        m_nack = 1'b0;
    endtask

    task automatic settle();
        for (int i = 0; i < GAPC + 6; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic extra;
        int   last;
        RST_N    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_nack   = 1'b0;
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_start", m_start, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_data", m_data, 0);
        RST_N = 1'b1;
        tick();

        // Single request on index 1, exact latency
        req_addr[15:8] = 8'hA0;
        req_data[15:8] = 8'h5C;
        req = 4'b0010;
        tick();
        chk("t1_grant_n1", grant, 0);
        tick();
        chk("t1_grant_n2", grant, 4'b0010);
        chk("t1_start_n2", m_start, 0);
        tick();
        chk("t1_start_n3", m_start, 1);
        chk("t1_addr", m_addr, 8'hA0);
        chk("t1_data", m_data, 8'h5C);
        master_resp(1'b0);
        chk("t1_done", done, 4'b0010);
        chk("t1_err", err, 0);
        req = '0;
        tick();
        chk("t1_done_pulse", done, 0);
        settle();
        chk("t1_grant_clear", grant, 0);

        // Reset during WAIT, then pointer must be back at 0
        req_addr[15:8] = 8'h77;
        req = 4'b0010;
        wait_start("t2_start", 10);
        tick();
        RST_N = 1'b0;
        #1;
        chk("t2_rst_grant", grant, 0);
        chk("t2_rst_start", m_start, 0);
        chk("t2_rst_addr", m_addr, 0);
        chk("t2_rst_data", m_data, 0);
        chk("t2_rst_done", done, 0);
        chk("t2_rst_err", err, 0);
        req = '0;
        tick();
        RST_N  = 1'b1;
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        chk("t2_stray_done", done, 0);
        chk("t2_stray_err", err, 0);
        req_addr[15:8] = 8'h11;
        req_addr[31:24] = 8'h33;
        req = 4'b1010;
        wait_start("t2_new_start", 10);
        chk("t2_new_grant", grant, 4'b0010);
        chk("t2_new_addr", m_addr, 8'h11);
        master_resp(1'b0);
        chk("t2_new_done", done, 4'b0010);
        req = '0;
        settle();

        // Two NACKs then ACK on index 2; bytes must not follow req_addr changes
        req_addr[23:16] = 8'h3C;
        req_data[23:16] = 8'h99;
        req = 4'b0100;
        wait_start("t3_start0", 10);
        chk("t3_addr0", m_addr, 8'h3C);
        chk("t3_data0", m_data, 8'h99);
        req_addr[23:16] = 8'hFF;
        req_data[23:16] = 8'h00;
        master_resp(1'b1);
        chk("t3_done0", done, 0);
        chk("t3_err0", err, 0);
        wait_start("t3_start1", 20);
        chk("t3_grant1", grant, 4'b0100);
        chk("t3_addr1", m_addr, 8'h3C);
        chk("t3_data1", m_data, 8'h99);
        master_resp(1'b1);
        chk("t3_done1", done, 0);
        chk("t3_err1", err, 0);
        wait_start("t3_start2", 20);
        chk("t3_addr2", m_addr, 8'h3C);
        master_resp(1'b0);
        chk("t3_done2", done, 4'b0100);
        chk("t3_err2", err, 0);
        req = '0;
        settle();

        // Always NACK on index 3, req dropped while granted
        req_addr[31:24] = 8'h50;
        req_data[31:24] = 8'h0F;
        req = 4'b1000;
        wait_start("t4_start0", 10);
        req = '0;
        master_resp(1'b1);
        chk("t4_err0", err, 0);
        wait_start("t4_start1", 20);
        chk("t4_addr1", m_addr, 8'h50);
        master_resp(1'b1);
        chk("t4_err1", err, 0);
        wait_start("t4_start2", 20);
        master_resp(1'b1);
        chk("t4_err2", err, 4'b1000);
        chk("t4_done2", done, 0);
        tick();
        chk("t4_err_pulse", err, 0);
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m_start) extra = 1'b1;
        end
        chk("t4_no_4th_start", extra, 0);
        chk("t4_grant_clear", grant, 0);

        // All four requesting: order 0,1,2,3,0
        for (int i = 0; i < 4; i++) begin
            req_addr[8*i +: 8] = 8'h10 + 8'(i);
            req_data[8*i +: 8] = 8'h20 + 8'(i);
        end
        req  = 4'b1111;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_start("t5_start", 30);
            chk("t5_grant", grant, 32'(1) << (k % 4));
            chk("t5_addr", m_addr, 32'h10 + 32'(k % 4));
            chk("t5_data", m_data, 32'h20 + 32'(k % 4));
            if (k > 0) chk("t5_spacing", 32'((cyc - last) >= GAPC + 1), 1);
            last = cyc;
            master_resp(1'b0);
            chk("t5_done", done, 32'(1) << (k % 4));
        end
        req = '0;
        settle();

        // Master busy for 10 cycles while in ISSUE
        m_busy = 1'b1;
        req_addr[7:0] = 8'hC3;
        req_data[7:0] = 8'h3C;
        req = 4'b0001;
        tick();
        tick();
        chk("t6_grant", grant, 4'b0001);
        chk("t6_start_hold", m_start, 0);
        req_addr[7:0] = 8'hEE;
        extra = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (m_start) extra = 1'b1;
        end
        chk("t6_no_start_busy", extra, 0);
        m_busy = 1'b0;
        tick();
        chk("t6_start", m_start, 1);
        chk("t6_addr", m_addr, 8'hC3);
        chk("t6_data", m_data, 8'h3C);
        master_resp(1'b0);
        chk("t6_done", done, 4'b0001);
        req = '0;
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
